// File: rtl/multiplier_pkg.sv
// Shared definitions for the multiplier family: controller states and Booth digit select codes.
// The radix-4 recoding rule lives here so every variant recodes identically.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_sel_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}; digit value = -2*b2 + b1 + b0.
    function automatic booth_sel_t booth_decode(input logic [2:0] triplet);
        booth_sel_t sel;
        case (triplet)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multiplier_radix4_if.sv
// Operation handshake and operand/result bus of the radix-4 multiplier.
// The master is the controller; the slave is the multiplier.
interface multiplier_radix4_if #(
    parameter int WIDTH = 32
);
    logic                 op_start;
    logic                 op_clear;
    logic                 op_signed;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   result;
    logic                 op_done;
    logic                 op_busy;

    modport master (
        output op_start, op_clear, op_signed, multiplicand, multiplier,
        input  result, op_done, op_busy
    );

    modport slave (
        input  op_start, op_clear, op_signed, multiplicand, multiplier,
        output result, op_done, op_busy
    );
endinterface

// File: rtl/booth_radix4_enc.sv
// Combinational radix-4 Booth encoder: one multiplier triplet selects 0, +-M or +-2M,
// delivered on WIDTH+3 bits so that 2M of a WIDTH+2 bit extended operand cannot overflow.
module booth_radix4_enc
    import multiplier_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       triplet,
    input  logic [WIDTH+1:0] m_ext,
    output booth_sel_t       sel,
    output logic [WIDTH+2:0] pp
);

    logic [WIDTH+2:0] m1;
    logic [WIDTH+2:0] m2;

    assign m1  = {m_ext[WIDTH+1], m_ext};
    assign m2  = {m_ext, 1'b0};
    assign sel = booth_decode(triplet);

    always_comb begin
        pp = '0;
        case (sel)
            POS1:    pp = m1;
            POS2:    pp = m2;
            NEG1:    pp = -m1;
            NEG2:    pp = -m2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/multiplier_radix4.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Retires two multiplier bits per EXEC cycle; can be relaunched straight from DONE.
module multiplier_radix4
    import multiplier_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    multiplier_radix4_if.slave  bus
);

    localparam int N     = WIDTH / 2 + 1;
    localparam int CNT_W = $clog2(N + 1);
    // After the N-th step the counter sits at N for one cycle while the product is captured.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N);

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [WIDTH+2:0]     acc_hi;
    logic [WIDTH+1:0]     acc_lo;
    logic                 q_prev;
    logic [WIDTH+1:0]     m_ext;

    logic [2*WIDTH-1:0]   result_q;
    logic                 done_q;
    logic                 busy_q;

    logic                 launch;
    logic                 stepping;
    logic                 finished;
    logic [WIDTH+1:0]     a_ext;
    logic [WIDTH+1:0]     b_ext;
    booth_sel_t           sel;
    logic [WIDTH+2:0]     pp;
    logic [WIDTH+2:0]     sum;
    logic [2*WIDTH+4:0]   shifted;
    logic [2*WIDTH-1:0]   product;

    assign launch   = bus.op_start && !bus.op_clear && (state != EXEC);
    assign stepping = (state == EXEC) && (count != CNT_LAST);
    assign finished = (state == EXEC) && (count == CNT_LAST);

    assign a_ext = bus.op_signed ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                 : {2'b00, bus.multiplicand};
    assign b_ext = bus.op_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                 : {2'b00, bus.multiplier};

    booth_radix4_enc #(.WIDTH(WIDTH)) u_enc (
        .triplet (({acc_lo[1:0], q_prev})),
        .m_ext   (m_ext),
        .sel     (sel),
        .pp      (pp)
    );

    // The multiplier bits drain out of acc_lo as the product bits shift in behind them.
    assign sum     = (sel == ZERO) ? acc_hi : acc_hi + pp;
    assign shifted = {{2{sum[WIDTH+2]}}, sum, acc_lo[WIDTH+1:2]};
    assign product = {acc_hi[WIDTH-3:0], acc_lo};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (bus.op_clear) begin
            state    <= IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                EXEC: begin
                    if (finished) begin
                        state    <= DONE;
                        result_q <= product;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.op_start) begin
                        state    <= EXEC;
                        result_q <= '0;
                        done_q   <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                default: begin
                    state    <= bus.op_start ? EXEC : IDLE;
                    result_q <= '0;
                    done_q   <= 1'b0;
                    busy_q   <= bus.op_start;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            q_prev <= 1'b0;
            m_ext  <= '0;
        end else if (bus.op_clear) begin
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            q_prev <= 1'b0;
        end else if (launch) begin
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= b_ext;
            q_prev <= 1'b0;
            m_ext  <= a_ext;
        end else if (stepping) begin
            count  <= count + CNT_W'(1);
            acc_hi <= shifted[2*WIDTH+4:WIDTH+2];
            acc_lo <= shifted[WIDTH+1:0];
            q_prev <= acc_lo[1];
        end
    end

    assign bus.result  = result_q;
    assign bus.op_done = done_q;
    assign bus.op_busy = busy_q;

endmodule

// File: tb/tb_multiplier_radix4.sv
// Bench for the radix-4 multiplier: directed corner cases on a 32-bit instance and
// randomized operands on an 8-bit instance, both against a plain-arithmetic product model.
module tb_multiplier_radix4;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    multiplier_radix4_if #(.WIDTH(32)) bus32 ();
    multiplier_radix4_if #(.WIDTH(8))  bus8 ();

    multiplier_radix4 #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(bus32.slave));
    multiplier_radix4 #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(bus8.slave));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Exact product of two w-bit operands, truncated to 2w bits.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input bit s, input int w);
        logic [63:0] wmask;
        logic [63:0] pmask;
        logic [63:0] ua;
        logic [63:0] ub;
        longint      sa;
        longint      sb;
        wmask = (64'd1 << w) - 64'd1;
        pmask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        ua = 64'(a) & wmask;
        ub = 64'(b) & wmask;
        if (s) begin
            sa = longint'(ua << (64 - w)) >>> (64 - w);
            sb = longint'(ub << (64 - w)) >>> (64 - w);
            return 64'(sa * sb) & pmask;
        end
        return (ua * ub) & pmask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit s, input string tag);
        int          lat;
        logic [63:0] exp;
        exp = ref_prod(a, b, s, 32);
        bus32.multiplicand = a;
        bus32.multiplier   = b;
        bus32.op_signed    = s;
        bus32.op_start     = 1'b1;
        tick();
        bus32.op_start = 1'b0;
        check({tag, " busy"}, 64'(bus32.op_busy), 64'd1);
        check({tag, " done_low"}, 64'(bus32.op_done), 64'd0);
        lat = 0;
        while (!bus32.op_done && lat < 40) begin
            bus32.multiplicand = $urandom;
            bus32.multiplier   = $urandom;
            bus32.op_signed    = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd18);
        check({tag, " result"}, bus32.result, exp);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit s, input string tag);
        int          lat;
        logic [63:0] exp;
        exp = ref_prod(32'(a), 32'(b), s, 8);
        bus8.multiplicand = a;
        bus8.multiplier   = b;
        bus8.op_signed    = s;
        bus8.op_start     = 1'b1;
        tick();
        bus8.op_start = 1'b0;
        lat = 0;
        while (!bus8.op_done && lat < 20) begin
            bus8.multiplicand = 8'($urandom);
            bus8.multiplier   = 8'($urandom);
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd6);
        check({tag, " result"}, 64'(bus8.result), exp);
    endtask

    initial begin
        bit seen_done;
        reset_n = 1'b0;
        bus32.op_start = 1'b0; bus32.op_clear = 1'b0; bus32.op_signed = 1'b0;
        bus32.multiplicand = '0; bus32.multiplier = '0;
        bus8.op_start = 1'b0; bus8.op_clear = 1'b0; bus8.op_signed = 1'b0;
        bus8.multiplicand = '0; bus8.multiplier = '0;
        tick();
        tick();
        check("rst result32", bus32.result, 64'd0);
        check("rst done32", 64'(bus32.op_done), 64'd0);
        check("rst busy32", 64'(bus32.op_busy), 64'd0);
        check("rst result8", 64'(bus8.result), 64'd0);
        check("rst done8", 64'(bus8.op_done), 64'd0);
        check("rst busy8", 64'(bus8.op_busy), 64'd0);
        reset_n = 1'b1;
        tick();

        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_ones");
        check("u_ones literal", bus32.result, 64'hFFFF_FFFE_0000_0001);
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "s_m1");
        check("s_m1 literal", bus32.result, 64'h0000_0000_0000_0001);
        run32(32'h8000_0000, 32'h8000_0000, 1'b1, "s_min");
        check("s_min literal", bus32.result, 64'h4000_0000_0000_0000);
        run32(32'd7, 32'hFFFF_FFFD, 1'b1, "s_7x-3");
        check("s_7x-3 literal", bus32.result, 64'hFFFF_FFFF_FFFF_FFEB);

        // DONE holds its result until a request arrives
        tick(); tick(); tick();
        check("hold done", 64'(bus32.op_done), 64'd1);
        check("hold result", bus32.result, 64'hFFFF_FFFF_FFFF_FFEB);
        run32(32'd3, 32'd5, 1'b0, "restart");
        check("restart literal", bus32.result, 64'd15);

        // abort in the fifth EXEC cycle
        bus32.multiplicand = 32'h1234_5678; bus32.multiplier = 32'h9ABC_DEF0;
        bus32.op_signed = 1'b0; bus32.op_start = 1'b1;
        tick();
        bus32.op_start = 1'b0;
        tick(); tick(); tick(); tick();
        bus32.op_clear = 1'b1;
        tick();
        bus32.op_clear = 1'b0;
        check("clr busy", 64'(bus32.op_busy), 64'd0);
        check("clr done", 64'(bus32.op_done), 64'd0);
        check("clr result", bus32.result, 64'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus32.op_done) seen_done = 1'b1;
        end
        check("clr no_done", 64'(seen_done), 64'd0);
        run32(32'hDEAD_BEEF, 32'h0000_1001, 1'b1, "after_clr");

        // reset in the middle of EXEC
        bus32.multiplicand = 32'h7FFF_FFFF; bus32.multiplier = 32'h7FFF_FFFF;
        bus32.op_signed = 1'b1; bus32.op_start = 1'b1;
        tick();
        bus32.op_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset_n = 1'b0;
        tick();
        check("midrst busy", 64'(bus32.op_busy), 64'd0);
        check("midrst done", 64'(bus32.op_done), 64'd0);
        check("midrst result", bus32.result, 64'd0);
        reset_n = 1'b1;
        tick();
        run32(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, "after_rst");

        for (int i = 0; i < 8; i++)
            run32($urandom, $urandom, 1'($urandom_range(0, 1)), "rand32");

        run8(8'h80, 8'h80, 1'b1, "w8_smin");
        run8(8'hFF, 8'hFF, 1'b0, "w8_uones");
        run8(8'hFF, 8'h01, 1'b1, "w8_m1x1");
        for (int i = 0; i < 40; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "rand8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
